// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 constants, event word and formatter byte-sequence helpers
package ps2_pkg;
  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } event_t;
  typedef enum logic [1:0] {IDLE, LOAD, SEND} fmt_state_t;
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return n < 4'd10 ? {4'h3, n} : 8'h37 + {4'h0, n};
  endfunction
  function automatic logic [3:0] seq_len(input event_t e, input logic raw);
    return raw ? 4'd1 + {3'b0, e.ext} + {3'b0, e.brk}
               : 4'd4 + {2'b0, e.ext, 1'b0} + {2'b0, e.brk, 1'b0};
  endfunction
  // Prefix text pairs sit on even indices, so i[0] picks letter vs '0'.
  function automatic logic [7:0] seq_byte(input event_t e, input logic [2:0] i, input logic raw);
    logic [2:0] p;
    logic [2:0] j;
    p = raw ? {2'b0, e.ext} + {2'b0, e.brk} : {1'b0, e.ext, 1'b0} + {1'b0, e.brk, 1'b0};
    j = i - p;
    if (raw)
      return i < p ? ((e.ext && i == 3'd0) ? PS2_EXT : PS2_BRK) : e.code;
    if (i < p)
      return i[0] ? 8'h30 : ((e.ext && i < 3'd2) ? 8'h45 : 8'h46);
    return j == 3'd0 ? hex_ascii(e.code[7:4]) :
           j == 3'd1 ? hex_ascii(e.code[3:0]) :
           j == 3'd2 ? ASCII_CR : ASCII_LF;
  endfunction
endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous FIFO with extra-bit pointers for full/empty distinction
module event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic wr_en, rd_en;
  assign level = wr - rd;
  assign full  = level == (AW+1)'(DEPTH);
  assign empty = wr == rd;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (wr_en) wr <= wr + 1'b1;
      if (rd_en) rd <= rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/ps2_key_event_bridge.sv
// ps2_key_event_bridge: PS/2 byte stream to make/break events, queued and serialised to a byte transmitter
module ps2_key_event_bridge
  import ps2_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int MODE          = 0,
  parameter int REPEAT_FILTER = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);
  logic ext_q, brk_q, held_v, is_pfx, dup, push, pop, full, empty, last;
  logic [8:0] held;
  logic [2:0] idx;
  event_t ev, cur, fifo_dout;
  fmt_state_t state, state_n;
  assign is_pfx = rx_byte == PS2_EXT || rx_byte == PS2_BRK;
  assign ev     = {brk_q, ext_q, rx_byte};
  assign dup    = REPEAT_FILTER != 0 && !ev.brk && held_v && held == {ev.ext, ev.code};
  assign push   = rx_valid && !is_pfx && !dup;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      held_v   <= 1'b0;
      held     <= '0;
      overflow <= 1'b0;
    end else begin
      if (rx_valid) begin
        ext_q <= (rx_byte == PS2_EXT) | (ext_q & is_pfx);
        brk_q <= (rx_byte == PS2_BRK) | (brk_q & is_pfx);
      end
      if (push && !ev.brk) begin
        held_v <= 1'b1;
        held   <= {ev.ext, ev.code};
      end else if (push && held == {ev.ext, ev.code}) begin
        held_v <= 1'b0;
      end
      if (push && full && !pop) overflow <= 1'b1;
    end
  event_fifo #(.WIDTH(10), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (ev),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );
  always_comb begin
    pop      = state == LOAD;
    tx_valid = state == SEND;
    tx_byte  = tx_valid ? seq_byte(cur, idx, MODE != 0) : 8'h00;
    last     = {1'b0, idx} == seq_len(cur, MODE != 0) - 4'd1;
    state_n  = state == IDLE ? (empty ? IDLE : LOAD) :
               state == LOAD ? SEND :
               (tx_ready && last) ? IDLE : SEND;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cur   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      if (state == LOAD) begin
        cur <= fifo_dout;
        idx <= '0;
      end else if (state == SEND && tx_ready) begin
        idx <= idx + 3'd1;
      end
    end
endmodule
